// File: rtl/johnson_pkg.sv
// Shared Johnson (twisted-ring) helpers: lock FSM states and a generic code decoder.
package johnson_pkg;

  localparam int JMAX_W = 32;
  localparam int JIDX_W = 6;

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} lock_state_e;

  typedef struct packed {
    logic              legal;
    logic [JIDX_W-1:0] idx;
  } jidx_t;

  // code must be zero-extended above width; width in 1..JMAX_W.
  function automatic jidx_t johnson_idx(input logic [JMAX_W-1:0] code, input int width);
    jidx_t       r;
    int          p;
    logic [63:0] low;
    logic [63:0] top;
    p = 0;
    for (int i = 0; i < JMAX_W; i++)
      if (i < width) p += int'(code[5'(i)]);
    low     = (64'd1 << p) - 64'd1;
    top     = low << (width - p);
    r.legal = ({32'd0, code} == low) || ({32'd0, code} == top);
    if (code == '0 || code[5'(width - 1)]) r.idx = JIDX_W'(p);
    else                                   r.idx = JIDX_W'(2 * width - p);
    return r;
  endfunction

endpackage

// File: rtl/johnson_decoder_if.sv
// Sample/decode bus between a Johnson counter tap and its decoder.
interface johnson_decoder_if #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
);
  localparam int IDXW = $clog2(2 * WIDTH);

  logic                 in_valid;
  logic [WIDTH-1:0]     in_code;
  logic                 out_valid;
  logic [IDXW-1:0]      out_idx;
  logic [2*WIDTH-1:0]   out_onehot;
  logic                 out_illegal;
  logic                 seq_err;
  logic                 wrap;
  logic                 locked;
  logic [ERR_W-1:0]     err_cnt;

  modport master (
    output in_valid, in_code,
    input  out_valid, out_idx, out_onehot, out_illegal, seq_err, wrap, locked, err_cnt
  );

  modport slave (
    input  in_valid, in_code,
    output out_valid, out_idx, out_onehot, out_illegal, seq_err, wrap, locked, err_cnt
  );
endinterface

// File: rtl/johnson_code_check.sv
// Combinational legality check and phase-index decode of one Johnson word.
module johnson_code_check
  import johnson_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int IDXW  = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] code_i,
  output logic             legal_o,
  output logic [IDXW-1:0]  idx_o
);
  jidx_t res;

  always_comb begin
    res     = johnson_idx(JMAX_W'(code_i), WIDTH);
    legal_o = res.legal;
    idx_o   = IDXW'(res.idx);
  end
endmodule

// File: rtl/johnson_decoder.sv
// Johnson counter decoder: legality, phase index/one-hot, successor check, lock FSM.
// Optional JOHNSON_DECODER_ERR_CNT_EN builds the saturating error counter; otherwise err_cnt is 0.
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input logic               clk,
  input logic               rst_n,
  johnson_decoder_if.slave  bus
);
  localparam int IDXW = $clog2(2 * WIDTH);
  localparam int NST  = 2 * WIDTH;
  localparam int LCW  = $clog2(LOCK_CNT + 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NST - 1);
  localparam logic [LCW-1:0]  LOCK_MAX = LCW'(LOCK_CNT);

  logic            legal;
  logic [IDXW-1:0] idx;

  johnson_code_check #(.WIDTH(WIDTH)) u_chk (
    .code_i  (bus.in_code),
    .legal_o (legal),
    .idx_o   (idx)
  );

  lock_state_e     state_q, state_d;
  logic            ref_vld_q, ref_vld_d;
  logic [IDXW-1:0] ref_q, ref_d;
  logic [LCW-1:0]  lock_q, lock_d;
  logic            vld_q, vld_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [NST-1:0]  oh_q, oh_d;
  logic            ill_q, ill_d;
  logic            seq_q, seq_d;
  logic            wrap_q, wrap_d;
  logic            err_inc;
  logic [IDXW-1:0] succ;

  assign succ = (ref_q == LAST_IDX) ? '0 : ref_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    ref_vld_d = ref_vld_q;
    ref_d     = ref_q;
    lock_d    = lock_q;
    vld_d     = bus.in_valid;
    idx_d     = idx_q;
    oh_d      = oh_q;
    ill_d     = ill_q;
    seq_d     = 1'b0;
    wrap_d    = 1'b0;
    err_inc   = 1'b0;
    if (bus.in_valid) begin
      if (!legal) begin
        ill_d     = 1'b1;
        idx_d     = '0;
        oh_d      = '0;
        ref_vld_d = 1'b0;
        lock_d    = '0;
        state_d   = HUNT;
        err_inc   = 1'b1;
      end else begin
        ill_d     = 1'b0;
        idx_d     = idx;
        oh_d      = {{(NST-1){1'b0}}, 1'b1} << idx;
        ref_vld_d = 1'b1;
        ref_d     = idx;
        // First word after reset/illegal only seeds the reference.
        if (ref_vld_q) begin
          if (idx == succ) begin
            wrap_d = (ref_q == LAST_IDX);
            if (lock_q != LOCK_MAX) lock_d = lock_q + 1'b1;
            if (lock_d == LOCK_MAX) state_d = LOCKED;
          end else begin
            seq_d   = 1'b1;
            err_inc = 1'b1;
            lock_d  = '0;
            state_d = HUNT;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      ref_vld_q <= 1'b0;
      ref_q     <= '0;
      lock_q    <= '0;
      vld_q     <= 1'b0;
      idx_q     <= '0;
      oh_q      <= '0;
      ill_q     <= 1'b0;
      seq_q     <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ref_vld_q <= ref_vld_d;
      ref_q     <= ref_d;
      lock_q    <= lock_d;
      vld_q     <= vld_d;
      idx_q     <= idx_d;
      oh_q      <= oh_d;
      ill_q     <= ill_d;
      seq_q     <= seq_d;
      wrap_q    <= wrap_d;
    end
  end

`ifdef JOHNSON_DECODER_ERR_CNT_EN
  logic [ERR_W-1:0] err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        err_q <= '0;
    else if (err_inc && err_q != '1)   err_q <= err_q + 1'b1;
  end

  assign bus.err_cnt = err_q;
`else
  logic err_inc_unused;
  assign err_inc_unused = err_inc;
  assign bus.err_cnt    = '0;
`endif

  assign bus.out_valid   = vld_q;
  assign bus.out_idx     = idx_q;
  assign bus.out_onehot  = oh_q;
  assign bus.out_illegal = ill_q;
  assign bus.seq_err     = seq_q;
  assign bus.wrap        = wrap_q;
  assign bus.locked      = (state_q == LOCKED);
endmodule
